// File: rtl/thread_fetch_sched.sv
// Four-thread barrel fetch scheduler: round-robin over enabled threads, per-thread PC.
// Define THREAD_ISSUE_CNT_EN to add per-thread 32-bit issue counters on issue_cnt.
module thread_fetch_sched #(
  parameter int PC_WIDTH = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          thread_en,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [3:0]          redirect_thread,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [PC_WIDTH-1:0] pc_IF,
  output logic [3:0]          thread_sel_IF,
  output logic                valid_IF,
  output logic [3:0]          thread_sel_ID
`ifdef THREAD_ISSUE_CNT_EN
  ,
  output logic [127:0]        issue_cnt
`endif
);

  logic [PC_WIDTH-1:0] pc_q [4];
  logic [PC_WIDTH-1:0] pc_d [4];
  logic [3:0]          sel_if_q, sel_if_d;
  logic                valid_q, valid_d;
  logic [3:0]          rr_last_q, rr_last_d;
  logic [3:0]          sel_id_q, sel_id_d;
  logic                issue;
  logic [3:0]          rr_base;
  logic [1:0]          base_idx;
  logic [1:0]          cand_idx;
  logic [3:0]          sel_next;

  assign issue = valid_q && !stall;

  // The search starts after the thread issuing this cycle, so the update of
  // rr_last is already reflected in the next choice.
  always_comb begin
    rr_base  = issue ? sel_if_q : rr_last_q;
    base_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (rr_base[i]) base_idx = 2'(i);
    end
    sel_next = 4'b0000;
    cand_idx = 2'd0;
    // Descending k so the nearest successor wins; k=4 revisits the base last.
    for (int k = 4; k >= 1; k--) begin
      cand_idx = base_idx + 2'(k);
      if (thread_en[cand_idx]) sel_next = 4'b0001 << cand_idx;
    end
  end

  always_comb begin
    sel_if_d  = sel_if_q;
    valid_d   = valid_q;
    rr_last_d = rr_last_q;
    sel_id_d  = sel_id_q;
    if (!stall) begin
      sel_if_d = sel_next;
      valid_d  = |thread_en;
      sel_id_d = issue ? sel_if_q : 4'b0000;
      if (issue) rr_last_d = sel_if_q;
    end
  end

  // Redirect beats increment; it ignores stall and thread_en.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pc_d[i] = pc_q[i];
      if (redirect_valid && redirect_thread[i]) pc_d[i] = redirect_pc;
      else if (issue && sel_if_q[i])            pc_d[i] = pc_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) pc_q[i] <= PC_WIDTH'(i) << (PC_WIDTH - 2);
      sel_if_q  <= 4'b0000;
      valid_q   <= 1'b0;
      rr_last_q <= 4'b1000;
      sel_id_q  <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) pc_q[i] <= pc_d[i];
      sel_if_q  <= sel_if_d;
      valid_q   <= valid_d;
      rr_last_q <= rr_last_d;
      sel_id_q  <= sel_id_d;
    end
  end

  always_comb begin
    pc_IF = '0;
    for (int i = 0; i < 4; i++) begin
      if (valid_q && sel_if_q[i]) pc_IF = pc_q[i];
    end
  end

  assign thread_sel_IF = sel_if_q;
  assign valid_IF      = valid_q;
  assign thread_sel_ID = sel_id_q;

`ifdef THREAD_ISSUE_CNT_EN
  logic [31:0] cnt_q [4];
  logic [31:0] cnt_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (issue && sel_if_q[i]) cnt_d[i] = cnt_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= 32'd0;
    end else begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign issue_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_thread_fetch_sched.sv
// Directed bench for thread_fetch_sched: round-robin order, enables, stall, redirect, wrap, reset.
module tb_thread_fetch_sched;

  logic       clk;
  logic       reset;
  logic [3:0] thread_en;
  logic       stall;
  logic       redirect_valid;
  logic [3:0] redirect_thread;
  logic [8:0] redirect_pc;
  logic [8:0] pc_IF;
  logic [3:0] thread_sel_IF;
  logic       valid_IF;
  logic [3:0] thread_sel_ID;
`ifdef THREAD_ISSUE_CNT_EN
  logic [127:0] issue_cnt;
`endif

  int total;
  int bad;

  thread_fetch_sched #(.PC_WIDTH(9)) dut (
    .clk            (clk),
    .reset          (reset),
    .thread_en      (thread_en),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_thread(redirect_thread),
    .redirect_pc    (redirect_pc),
    .pc_IF          (pc_IF),
    .thread_sel_IF  (thread_sel_IF),
    .valid_IF       (valid_IF),
    .thread_sel_ID  (thread_sel_ID)
`ifdef THREAD_ISSUE_CNT_EN
    ,
    .issue_cnt      (issue_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] sel, input logic [8:0] pc,
                         input logic vld, input logic [3:0] id);
    chk({tag, ".sel_IF"}, 32'(thread_sel_IF), 32'(sel));
    chk({tag, ".pc_IF"},  32'(pc_IF),         32'(pc));
    chk({tag, ".valid"},  32'(valid_IF),      32'(vld));
    chk({tag, ".sel_ID"}, 32'(thread_sel_ID), 32'(id));
  endtask

  task automatic do_reset(input logic [3:0] en);
    @(negedge clk);
    reset     = 1'b1;
    thread_en = en;
    stall     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_thread = 4'b0000;
    redirect_pc     = 9'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [3:0] a_sel [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [8:0] a_pc  [8] = '{9'd0, 9'd128, 9'd256, 9'd384, 9'd1, 9'd129, 9'd257, 9'd385};
  logic [3:0] a_id  [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    thread_en = 4'b1111;
    stall = 1'b0;
    redirect_valid  = 1'b0;
    redirect_thread = 4'b0000;
    redirect_pc     = 9'd0;
    #2;
    chk_out("reset", 4'b0000, 9'd0, 1'b0, 4'b0000);

    // All threads enabled: strict rotation, PCs from each memory quarter.
    do_reset(4'b1111);
    for (int k = 0; k < 8; k++) begin
      step();
      chk_out($sformatf("rr%0d", k), a_sel[k], a_pc[k], 1'b1, a_id[k]);
    end
    step();
    chk_out("rr8", 4'b0001, 9'd2, 1'b1, 4'b1000);
`ifdef THREAD_ISSUE_CNT_EN
    for (int i = 0; i < 4; i++) chk($sformatf("cnt%0d", i), issue_cnt[32*i +: 32], 32'd2);
`endif
    // Mid-run reset under stall takes effect without a clock edge.
    stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk_out("midrst", 4'b0000, 9'd0, 1'b0, 4'b0000);
`ifdef THREAD_ISSUE_CNT_EN
    for (int i = 0; i < 4; i++) chk($sformatf("cnt_rst%0d", i), issue_cnt[32*i +: 32], 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    step();
    chk_out("postrst", 4'b0001, 9'd0, 1'b1, 4'b0000);

    // Threads 0 and 2 only, then all disabled.
    do_reset(4'b0101);
    step(); chk_out("en0101_a", 4'b0001, 9'd0,   1'b1, 4'b0000);
    step(); chk_out("en0101_b", 4'b0100, 9'd256, 1'b1, 4'b0001);
    step(); chk_out("en0101_c", 4'b0001, 9'd1,   1'b1, 4'b0100);
    step(); chk_out("en0101_d", 4'b0100, 9'd257, 1'b1, 4'b0001);
    thread_en = 4'b0000;
    step(); chk_out("en0000_a", 4'b0000, 9'd0, 1'b0, 4'b0100);
    step(); chk_out("en0000_b", 4'b0000, 9'd0, 1'b0, 4'b0000);
    thread_en = 4'b0100;
    step(); chk_out("en0100", 4'b0100, 9'd258, 1'b1, 4'b0000);

    // Stall while thread 1 is presented at pc 129.
    do_reset(4'b1111);
    for (int k = 0; k < 6; k++) step();
    chk_out("pre_stall", 4'b0010, 9'd129, 1'b1, 4'b0001);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out($sformatf("stall%0d", k), 4'b0010, 9'd129, 1'b1, 4'b0001);
    end
    stall = 1'b0;
    step(); chk_out("unstall_a", 4'b0100, 9'd257, 1'b1, 4'b0010);
    step(); chk_out("unstall_b", 4'b1000, 9'd385, 1'b1, 4'b0100);
    step(); chk_out("unstall_c", 4'b0001, 9'd2,   1'b1, 4'b1000);
    step(); chk_out("unstall_d", 4'b0010, 9'd130, 1'b1, 4'b0001);

    // Redirect of thread 1 in the cycle it issues beats the increment.
    redirect_valid  = 1'b1;
    redirect_thread = 4'b0010;
    redirect_pc     = 9'd300;
    step(); chk_out("redir_a", 4'b0100, 9'd258, 1'b1, 4'b0010);
    redirect_valid = 1'b0;
    step(); chk_out("redir_b", 4'b1000, 9'd386, 1'b1, 4'b0100);
    step(); chk_out("redir_c", 4'b0001, 9'd3,   1'b1, 4'b1000);
    step(); chk_out("redir_d", 4'b0010, 9'd300, 1'b1, 4'b0001);
    // Redirect lands even while stalled.
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 9'd50;
    step(); chk_out("redir_stall", 4'b0010, 9'd50, 1'b1, 4'b0001);
    stall = 1'b0;
    redirect_valid = 1'b0;
    step(); chk_out("redir_post", 4'b0100, 9'd259, 1'b1, 4'b0010);
    step(); chk_out("redir_post2", 4'b1000, 9'd387, 1'b1, 4'b0100);
    step(); chk_out("redir_post3", 4'b0001, 9'd4,   1'b1, 4'b1000);
    step(); chk_out("redir_post4", 4'b0010, 9'd51,  1'b1, 4'b0001);
    // Empty target mask leaves PCs alone.
    redirect_valid  = 1'b1;
    redirect_thread = 4'b0000;
    redirect_pc     = 9'd7;
    step(); chk_out("redir_none", 4'b0100, 9'd260, 1'b1, 4'b0010);
    redirect_valid = 1'b0;

    // Single thread 3 preset to 511 wraps to 0 and issues every cycle.
    do_reset(4'b1000);
    redirect_valid  = 1'b1;
    redirect_thread = 4'b1000;
    redirect_pc     = 9'd511;
    step(); chk_out("wrap_a", 4'b1000, 9'd511, 1'b1, 4'b0000);
    redirect_valid = 1'b0;
    step(); chk_out("wrap_b", 4'b1000, 9'd0, 1'b1, 4'b1000);
    step(); chk_out("wrap_c", 4'b1000, 9'd1, 1'b1, 4'b1000);
`ifdef THREAD_ISSUE_CNT_EN
    chk("cnt_wrap3", issue_cnt[127:96], 32'd2);
    chk("cnt_wrap0", issue_cnt[31:0],   32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
